// File: rtl/key_pkg.sv
// Shared definitions for the push-button front end: state encoding and
// default timing constants (50 MHz system clock).
package key_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRESS_DB   = 3'd1,
    HELD       = 3'd2,
    REPEAT     = 3'd3,
    RELEASE_DB = 3'd4
  } key_state_t;

  localparam int DEF_DEBOUNCE_CNT = 1_000_000;  // 20 ms
  localparam int DEF_LONG_CNT     = 50_000_000; // 1 s
  localparam int DEF_REPEAT_CNT   = 10_000_000; // 200 ms

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit board input.
// RST_VAL sets the value both flops take under reset (the input's idle level).
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_debounce_rpt.sv
// Push-button front end: synchronise and debounce an active-low key, emit
// one-cycle press/release events and auto-repeat press events on long hold.
module key_debounce_rpt
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT,
  parameter int LONG_CNT     = DEF_LONG_CNT,
  parameter int REPEAT_CNT   = DEF_REPEAT_CNT
) (
  input  logic clk,
  input  logic rst,
  input  logic anjian,
  output logic key_pulse,
  output logic key_release,
  output logic key_down,
  output logic key_long
);

  localparam int CNT_MAX = max3(DEBOUNCE_CNT, LONG_CNT, REPEAT_CNT);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CNT - 1);

  logic             sync_key;
  key_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr;
  logic             pulse_nxt;
  logic             release_nxt;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (anjian),
    .q   (sync_key)
  );

  // A release level always wins over a timer expiry in the same cycle, so a
  // repeat tick can never coincide with the start of release debounce.
  always_comb begin
    state_nxt   = state;
    cnt_clr     = 1'b0;
    pulse_nxt   = 1'b0;
    release_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (!sync_key) state_nxt = PRESS_DB;
      end
      PRESS_DB: begin
        if (sync_key) begin
          state_nxt = IDLE;
        end else if (cnt == DB_LAST) begin
          state_nxt = HELD;
          pulse_nxt = 1'b1;
        end
      end
      HELD: begin
        if (sync_key) begin
          state_nxt = RELEASE_DB;
        end else if (cnt == LONG_LAST) begin
          state_nxt = REPEAT;
          pulse_nxt = 1'b1;
        end
      end
      REPEAT: begin
        if (sync_key) begin
          state_nxt = RELEASE_DB;
        end else if (cnt == RPT_LAST) begin
          cnt_clr   = 1'b1;
          pulse_nxt = 1'b1;
        end
      end
      RELEASE_DB: begin
        if (!sync_key) begin
          state_nxt = HELD;
        end else if (cnt == DB_LAST) begin
          state_nxt   = IDLE;
          release_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Counter saturates rather than wrapping; only IDLE can sit long enough to hit it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if ((state_nxt != state) || cnt_clr) begin
        cnt <= '0;
      end else if (cnt != {CNT_W{1'b1}}) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      key_pulse   <= 1'b0;
      key_release <= 1'b0;
      key_down    <= 1'b0;
      key_long    <= 1'b0;
    end else begin
      key_pulse   <= pulse_nxt;
      key_release <= release_nxt;
      key_down    <= (state_nxt == HELD) || (state_nxt == REPEAT) ||
                     (state_nxt == RELEASE_DB);
      key_long    <= (state_nxt == REPEAT);
    end
  end

endmodule

// File: tb/tb_key_debounce_rpt.sv
// Directed bench for key_debounce_rpt with short timing constants.
// Output vector compared each cycle is {key_pulse, key_release, key_down, key_long}.
module tb_key_debounce_rpt;
  import key_pkg::*;

  localparam int DB  = 4;
  localparam int LG  = 20;
  localparam int RP  = 8;

  logic clk;
  logic rst;
  logic anjian;
  logic key_pulse;
  logic key_release;
  logic key_down;
  logic key_long;

  int total;
  int bad;

  key_debounce_rpt #(
    .DEBOUNCE_CNT(DB),
    .LONG_CNT    (LG),
    .REPEAT_CNT  (RP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .anjian     (anjian),
    .key_pulse  (key_pulse),
    .key_release(key_release),
    .key_down   (key_down),
    .key_long   (key_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] got;
    rst    = 1'b0;
    anjian = 1'b1;
    repeat (3) tick();
    got = {key_pulse, key_release, key_down, key_long};
    total++;
    if (got !== 4'b0000) begin
      bad++;
      $display("FAIL reset_hold got=%b exp=0000", got);
    end
    rst = 1'b1;
    repeat (5) tick();
    got = {key_pulse, key_release, key_down, key_long};
    total++;
    if (got !== 4'b0000) begin
      bad++;
      $display("FAIL reset_idle got=%b exp=0000", got);
    end
  endtask

  task automatic test_release(input logic was_long);
    logic [3:0] got, exp;
    anjian = 1'b1;
    for (int r = 1; r <= 12; r++) begin
      tick();
      got = {key_pulse, key_release, key_down, key_long};
      exp = {1'b0, (r == 7), (r < 7), (was_long && (r < 3))};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL release r=%0d got=%b exp=%b", r, got, exp);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [3:0] got, exp;
    anjian = 1'b0;
    for (int e = 1; e <= 15; e++) begin
      tick();
      got = {key_pulse, key_release, key_down, key_long};
      exp = {(e == 7), 1'b0, (e >= 7), 1'b0};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL clean_press e=%0d got=%b exp=%b", e, got, exp);
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] got;
    for (int e = 1; e <= 20; e++) begin
      anjian = (e == 1 || e == 2 || e == 4 || e == 5) ? 1'b0 : 1'b1;
      tick();
      got = {key_pulse, key_release, key_down, key_long};
      total++;
      if (got !== 4'b0000) begin
        bad++;
        $display("FAIL bounce e=%0d got=%b exp=0000", e, got);
      end
    end
  endtask

  task automatic test_long_hold();
    logic [3:0] got, exp;
    logic       p;
    anjian = 1'b0;
    for (int e = 1; e <= 60; e++) begin
      tick();
      p   = (e == 7) || (e == 27) || (e == 35) || (e == 43) || (e == 51) || (e == 59);
      got = {key_pulse, key_release, key_down, key_long};
      exp = {p, 1'b0, (e >= 7), (e >= 27)};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL long_hold e=%0d got=%b exp=%b", e, got, exp);
      end
    end
  endtask

  task automatic test_release_bounce();
    logic [3:0] got, exp;
    for (int e = 1; e <= 40; e++) begin
      anjian = (e == 11 || e == 12) ? 1'b1 : 1'b0;
      tick();
      got = {key_pulse, key_release, key_down, key_long};
      exp = {(e == 7) || (e == 35), 1'b0, (e >= 7), (e >= 35)};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL release_bounce e=%0d got=%b exp=%b", e, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [3:0] got, exp;
    anjian = 1'b0;
    for (int e = 1; e <= 30; e++) begin
      if (e == 30) rst = 1'b0;
      tick();
      got = {key_pulse, key_release, key_down, key_long};
      if (e == 30) exp = 4'b0000;
      else         exp = {(e == 7) || (e == 27), 1'b0, (e >= 7), (e >= 27)};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL reset_mid e=%0d got=%b exp=%b", e, got, exp);
      end
    end
    rst = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      got = {key_pulse, key_release, key_down, key_long};
      exp = {(k == 7), 1'b0, (k >= 7), 1'b0};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL reset_repress k=%0d got=%b exp=%b", k, got, exp);
      end
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst    = 1'b0;
    anjian = 1'b1;
    test_reset();
    test_clean_press();
    test_release(1'b0);
    test_bounce();
    test_long_hold();
    test_release(1'b1);
    test_release_bounce();
    test_release(1'b1);
    test_reset_mid_hold();
    test_release(1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
